// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmitter: FSM states, frame shape, divider.
// No logic of its own; latency and backpressure are defined by the modules that import it.
// Idle line level and frame length are kept here so the arbiter and any receiver model agree.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam int   FRAME_BITS = 10;
    localparam int   DATA_BITS  = FRAME_BITS - 2;
    localparam logic LINE_IDLE  = 1'b1;

    // Rounded clock cycles per bit; callers must keep the result >= 2.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..DIV-1 and flags the last cycle of each bit period.
// Latency: tick is combinational from the count; clear takes effect on the next edge.
// No backpressure; free-running unless cleared.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Two byte requesters share one 8N1 TX line, round-robin per frame, frame start gated by CTS.
// Latency: tx falls on the first edge after the valid/ready handshake; a frame lasts 10*DIV cycles.
// Backpressure: ready is offered only in IDLE with CTS clear, to at most one requester at a time.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200,
    parameter bit CTS_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s0_data,
    input  logic       s0_valid,
    output logic       s0_ready,
    input  logic [7:0] s1_data,
    input  logic       s1_valid,
    output logic       s1_ready,
    input  logic       cts,
    output logic       tx,
    output logic       rts,
    output logic       busy,
    output logic       grant_id
);

    localparam int DIV = calc_div(CLK_HZ, BAUD);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    tx_state_e  state;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       last_grant;
    logic       cts_meta, cts_sync;
    logic       cts_ok;
    logic       hs;
    logic       hs_sel;
    logic [7:0] hs_dat;
    logic       tick;

    // cts is asynchronous; flops reset to "not clear" so nothing starts before it is seen low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_meta <= 1'b1;
            cts_sync <= 1'b1;
        end else begin
            cts_meta <= cts;
            cts_sync <= cts_meta;
        end
    end

    assign cts_ok = !CTS_EN || !cts_sync;

    // With both pending, the requester that did not own the last frame wins.
    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (state == ST_IDLE && cts_ok) begin
            if (s0_valid && (!s1_valid || last_grant)) begin
                s0_ready = 1'b1;
            end else if (s1_valid) begin
                s1_ready = 1'b1;
            end
        end
    end

    assign hs     = (s0_valid && s0_ready) || (s1_valid && s1_ready);
    assign hs_sel = s1_ready;
    assign hs_dat = s1_ready ? s1_data : s0_data;
    assign rts    = 1'b0;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (hs),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            shift      <= '0;
            bit_cnt    <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            tx         <= LINE_IDLE;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= LINE_IDLE;
                    if (hs) begin
                        state      <= ST_START;
                        shift      <= hs_dat;
                        bit_cnt    <= '0;
                        grant_id   <= hs_sel;
                        last_grant <= hs_sel;
                        tx         <= ~LINE_IDLE;
                        busy       <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        state <= ST_DATA;
                        tx    <= shift[0];
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            state <= ST_STOP;
                            tx    <= LINE_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= LINE_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: DIV=10 instance with CTS honoured, DIV=2 instance with CTS ignored.
// A line receiver decodes tx and checks each frame against the scoreboard queue.
module tb_uart_tx_arbiter;

    localparam int DIV = 10;

    typedef struct packed {
        logic       gid;
        logic [7:0] dat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] s0_data, s1_data;
    logic       s0_valid, s1_valid, s0_ready, s1_ready;
    logic       cts, tx, rts, busy, grant_id;

    logic [7:0] d2_s0_data, d2_s1_data;
    logic       d2_s0_valid, d2_s1_valid, d2_s0_ready, d2_s1_ready;
    logic       d2_cts, d2_tx, d2_rts, d2_busy, d2_grant_id;

    uart_tx_arbiter #(.CLK_HZ(1000), .BAUD(100), .CTS_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .cts(cts), .tx(tx), .rts(rts), .busy(busy), .grant_id(grant_id)
    );

    uart_tx_arbiter #(.CLK_HZ(200), .BAUD(100), .CTS_EN(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .s0_data(d2_s0_data), .s0_valid(d2_s0_valid), .s0_ready(d2_s0_ready),
        .s1_data(d2_s1_data), .s1_valid(d2_s1_valid), .s1_ready(d2_s1_ready),
        .cts(d2_cts), .tx(d2_tx), .rts(d2_rts), .busy(d2_busy), .grant_id(d2_grant_id)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int viol_both = 0;
    int viol_busy = 0;
    exp_t exp_q[$];
    logic [19:0] q2[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (s0_ready && s1_ready) viol_both++;
            if ((s0_ready || s1_ready) && busy) viol_busy++;
            if (d2_s0_ready && d2_s1_ready) viol_both++;
            if ((d2_s0_ready || d2_s1_ready) && d2_busy) viol_busy++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Line receiver: samples mid-bit, abandons a frame if reset hits it.
    initial begin : rx_mon
        logic       prev, st, sp, gid, ab;
        logic [7:0] rb;
        exp_t       e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !tx) begin
                gid = grant_id; ab = 1'b0; st = 1'b0; sp = 1'b0; rb = '0;
                for (int b = 0; b < 10 && !ab; b++) begin
                    for (int k = 0; k < ((b == 0) ? DIV / 2 : DIV); k++) begin
                        @(negedge clk);
                        if (!rst_n) ab = 1'b1;
                    end
                    if (b == 0) st = tx;
                    else if (b < 9) rb[b-1] = tx;
                    else sp = tx;
                end
                if (!ab) begin
                    chk("rx_start", st, 0);
                    chk("rx_stop", sp, 1);
                    chk("rx_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("rx_data", rb, e.dat);
                        chk("rx_grant", gid, e.gid);
                    end
                end
            end
            prev = tx;
        end
    end

    task automatic wait_hs(input bit req, output int w);
        w = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (req ? (s1_valid && s1_ready) : (s0_valid && s0_ready)) begin
                w = i;
                break;
            end
        end
        chk("hs_timeout", w >= 0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic busy_len(output int n);
        n = 0;
        @(negedge clk);
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic reset_dut();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    int w, n, hs, last, viol, hs_edge;

    initial begin
        rst_n = 1'b0;
        s0_data = '0; s1_data = '0; s0_valid = 1'b1; s1_valid = 1'b1; cts = 1'b0;
        d2_s0_data = '0; d2_s1_data = '0; d2_s0_valid = 1'b0; d2_s1_valid = 1'b0; d2_cts = 1'b1;

        // 1: reset state, valids pending but nothing may be accepted
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_s0_ready", s0_ready, 0);
        chk("rst_s1_ready", s1_ready, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_rts", rts, 0);
        chk("rst_d2_tx", d2_tx, 1);
        @(posedge clk); #1 s0_valid = 1'b0; s1_valid = 1'b0;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_tx", tx, 1);

        // 2: single byte from s0
        @(posedge clk); #1 s0_data = 8'hA5; s0_valid = 1'b1;
        exp_q.push_back('{gid: 1'b0, dat: 8'hA5});
        wait_hs(1'b0, w);
        chk("t2_ready_same_cycle", w, 0);
        @(posedge clk); #1 s0_valid = 1'b0;
        @(negedge clk);
        chk("t2_lat_tx", tx, 0);
        chk("t2_lat_busy", busy, 1);
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
        chk("t2_busy_len", n, 10 * DIV);

        // 3: both requesters continuously valid, from a fresh reset
        reset_dut();
        for (int i = 0; i < 4; i++)
            exp_q.push_back('{gid: i[0], dat: i[0] ? 8'h22 : 8'h11});
        @(posedge clk); #1 s0_data = 8'h11; s1_data = 8'h22; s0_valid = 1'b1; s1_valid = 1'b1;
        hs = 0; last = 0;
        for (int i = 0; i < 1000 && hs < 4; i++) begin
            @(negedge clk);
            if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) begin
                chk("t3_rr_order", s1_ready, hs % 2);
                if (hs > 0) chk("t3_b2b_gap", cyc - last, 10 * DIV + 1);
                last = cyc;
                hs++;
            end
        end
        chk("t3_hs_count", hs, 4);
        @(posedge clk); #1 s0_valid = 1'b0; s1_valid = 1'b0;
        wait_idle();

        // 4: cts gating of frame start, cts rise mid-frame
        @(posedge clk); #1 cts = 1'b1;
        repeat (4) @(posedge clk);
        #1 s1_data = 8'h3C; s1_valid = 1'b1;
        viol = 0;
        repeat (10) begin
            @(negedge clk);
            if (s1_ready || !tx) viol++;
        end
        chk("t4_cts_hold", viol, 0);
        @(posedge clk); #1 cts = 1'b0;
        exp_q.push_back('{gid: 1'b1, dat: 8'h3C});
        hs_edge = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (s1_ready) begin
                hs_edge = i;
                break;
            end
        end
        chk("t4_cts_lat", hs_edge, 3);
        @(posedge clk); #1 s1_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 cts = 1'b1; s0_data = 8'h77; s0_valid = 1'b1;
        wait_idle();
        viol = 0;
        repeat (30) begin
            @(negedge clk);
            if (s0_ready || busy || !tx) viol++;
        end
        chk("t4_withheld", viol, 0);
        @(posedge clk); #1 s0_valid = 1'b0; cts = 1'b0;
        repeat (5) @(posedge clk);

        // 5: reset during data bit 3, pending byte restarts a full frame
        #1 s0_data = 8'h5A; s0_valid = 1'b1;
        exp_q.push_back('{gid: 1'b0, dat: 8'h5A});
        wait_hs(1'b0, w);
        @(posedge clk);
        repeat (45) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_rst_tx", tx, 1);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", s0_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_hs(1'b0, w);
        chk("t5_restart_wait", w, 2);
        @(posedge clk); #1 s0_valid = 1'b0;
        busy_len(n);
        chk("t5_busy_len", n, 10 * DIV);

        // 6: DIV=2 instance ignores cts (held high)
        for (int f = 0; f < 2; f++) begin
            logic [7:0]  b;
            logic [9:0]  fb;
            logic [19:0] ev, gv;
            int          bz;
            b  = (f == 0) ? 8'hC3 : 8'h5E;
            fb = {1'b1, b, 1'b0};
            for (int c = 0; c < 20; c++) ev[c] = fb[c/2];
            q2.push_back(ev);
            @(posedge clk); #1;
            if (f == 0) begin d2_s0_data = b; d2_s0_valid = 1'b1; end
            else begin d2_s1_data = b; d2_s1_valid = 1'b1; end
            w = -1;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if ((d2_s0_valid && d2_s0_ready) || (d2_s1_valid && d2_s1_ready)) begin
                    w = i;
                    break;
                end
            end
            chk("t6_hs_wait", w, 0);
            @(posedge clk); #1 d2_s0_valid = 1'b0; d2_s1_valid = 1'b0;
            bz = 0; gv = '0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                gv[c] = d2_tx;
                if (!d2_busy) bz++;
            end
            chk("t6_busy_gaps", bz, 0);
            chk("t6_grant", d2_grant_id, f);
            @(negedge clk);
            chk("t6_busy_end", d2_busy, 0);
            chk("t6_frame", gv, q2.pop_front());
            chk("t6_rts", d2_rts, 0);
            repeat (2) @(posedge clk);
        end

        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk("sb_drain", exp_q.size(), 0);
        chk("q2_drain", q2.size(), 0);
        chk("rdy_exclusive", viol_both, 0);
        chk("rdy_while_busy", viol_busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
